csa_seq_mul: RTL and testbench

- Iterative shift-add multiplier that sits directly upstream of the CSA3T2 carry-save adder: generates one partial product per cycle and feeds it to CSA3T2.
- Holds the running product in redundant (sum, carry) form, so no carry propagates inside the loop.
- A single final carry-propagate add plus sign fix-up produces the 2*WIDTH product.
- Serves as the multi-cycle M-extension multiplier backend (MUL/MULH/MULHSU/MULHU selection done by caller from out_prod).

---
 rtl/mul_pkg.sv | 20 ++
 rtl/csa3t2.sv | 18 +
 rtl/csa_seq_mul.sv | 132 +++++++++++++
 tb/tb_csa_seq_mul.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the sequential carry-save multiplier
package mul_pkg;

  // Default operand width of the multiplier backend.
  localparam int MUL_WIDTH = 32;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL     = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Bit-counter width for a given operand width (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/csa3t2.sv
// rtl/csa3t2.sv - 3:2 carry-save adder, one full adder per bit
module csa3t2 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] cout
);

  // Bitwise sum and majority; cout[i] carries weight 2^(i+1).
  always_comb begin
    out  = in_a ^ in_b ^ in_c;
    cout = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
  end

endmodule

// File: rtl/csa_seq_mul.sv
// rtl/csa_seq_mul.sv - iterative shift-add multiplier with redundant accumulator
module csa_seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_a_signed,
  input  logic                 in_b_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_sum_q, acc_sum_d;
  logic [PW-1:0]    acc_carry_q, acc_carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [PW-1:0]    pp;
  logic [PW-1:0]    carry_sh;
  logic [PW-1:0]    csa_sum;
  logic [PW-1:0]    csa_cout;
  logic [PW-1:0]    p_sum;
  logic             a_neg;
  logic             b_neg;

  // Partial product for the current multiplier bit and the re-weighted carry vector.
  always_comb begin
    carry_sh = acc_carry_q << 1;
    pp       = mag_b_q[cnt_q] ? ({{WIDTH{1'b0}}, mag_a_q} << cnt_q) : '0;
    p_sum    = acc_sum_q + carry_sh;
  end

  csa3t2 #(
    .WIDTH (PW)
  ) u_csa (
    .in_a (acc_sum_q),
    .in_b (carry_sh),
    .in_c (pp),
    .out  (csa_sum),
    .cout (csa_cout)
  );

  // Next-state logic: operand capture, per-bit compression, final resolve and handshake.
  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    neg_d       = neg_q;
    acc_sum_d   = acc_sum_q;
    acc_carry_d = acc_carry_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    a_neg       = in_a_signed && in_a[WIDTH-1];
    b_neg       = in_b_signed && in_b[WIDTH-1];
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Magnitude of the most negative value wraps to itself, which is correct unsigned.
          mag_a_d     = a_neg ? (~in_a + 1'b1) : in_a;
          mag_b_d     = b_neg ? (~in_b + 1'b1) : in_b;
          neg_d       = a_neg ^ b_neg;
          acc_sum_d   = '0;
          acc_carry_d = '0;
          cnt_d       = '0;
          state_d     = MUL;
        end
      end
      MUL: begin
        acc_sum_d   = csa_sum;
        acc_carry_d = csa_cout;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        prod_d  = neg_q ? (~p_sum + 1'b1) : p_sum;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      neg_q       <= 1'b0;
      acc_sum_q   <= '0;
      acc_carry_q <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      neg_q       <= neg_d;
      acc_sum_q   <= acc_sum_d;
      acc_carry_q <= acc_carry_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
    end
  end

  assign out_prod = prod_q;

endmodule

// File: tb/tb_csa_seq_mul.sv
// tb/tb_csa_seq_mul.sv - self-checking bench for csa_seq_mul against an arithmetic model
module tb_csa_seq_mul;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_a_signed;
  logic           in_b_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;

  int n_total = 0;
  int n_pass  = 0;

  csa_seq_mul #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_a_signed (in_a_signed),
    .in_b_signed (in_b_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_prod    (out_prod)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Product of the operands interpreted per their sign flags, truncated to 2*W bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
    logic [127:0] ea, eb, p;
    ea = sa ? {{96{a[31]}}, a} : {96'b0, a};
    eb = sb ? {{96{b[31]}}, b} : {96'b0, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                        input logic sb, input int hold, input string tag);
    logic [63:0] exp;
    int guard;
    int lat;
    exp = ref_mul(a, b, sa, sb);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_a_signed = sa; in_b_signed = sb;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check({tag, " accept_timeout"}, 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    in_a_signed = 1'($urandom); in_b_signed = 1'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check({tag, " latency"}, 64'(lat), 64'd34);
    check({tag, " prod"}, out_prod, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold_ready"}, 64'(in_ready), 64'd0);
      check({tag, " hold_prod"}, out_prod, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " post_ready"}, 64'(in_ready), 64'd1);
    check({tag, " post_valid"}, 64'(out_valid), 64'd0);
    check({tag, " post_prod"}, out_prod, exp);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_a_signed = 1'b0; in_b_signed = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_prod", out_prod, 64'd0);

    run_op(32'd3, 32'd5, 1'b0, 1'b0, 0, "unsigned_basic");
    check("unsigned_basic const", out_prod, 64'h0000_0000_0000_000F);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 0, "signed_mix");
    check("signed_mix const", out_prod, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1, 0, "unsigned_a_mix");
    check("unsigned_a_mix const", out_prod, 64'h0000_0004_FFFF_FFF1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, "max_unsigned");
    check("max_unsigned const", out_prod, 64'hFFFF_FFFE_0000_0001);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 0, "min_signed_sq");
    check("min_signed_sq const", out_prod, 64'h4000_0000_0000_0000);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, "mulhsu_corner");
    check("mulhsu_corner const", out_prod, 64'h8000_0000_8000_0000);
    run_op(32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, "zero_a");
    run_op(32'h8000_0001, 32'h0, 1'b1, 1'b0, 0, "zero_b");
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 10, "backpressure");

    // Reset while the loop is at bit 12; nothing may emerge afterwards.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h7; in_b = 32'h9; in_a_signed = 1'b0; in_b_signed = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset in_ready", 64'(in_ready), 64'd1);
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset out_prod", out_prod, 64'd0);
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    check("midreset no_stale", 64'(seen), 64'd0);

    for (int k = 0; k < 1000; k++) begin
      logic [31:0] ra, rb;
      int mode;
      mode = $urandom_range(0, 7);
      ra = $urandom; rb = $urandom;
      if (mode == 0) ra = 32'h8000_0000;
      if (mode == 1) rb = 32'hFFFF_FFFF;
      if (mode == 2) ra = 32'h0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
